// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over req/ack,
// holds them for the decoder and steers the PC on consume.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD
  } state_t;

  state_t state;
  state_t stateNext;

  logic [31:0] pcReg;
  logic [31:0] instrReg;
  logic [31:0] retiredCnt;
  logic [31:0] pcPlus4;
  logic [31:0] nextPc;
  logic [31:0] brOffset;
  logic        capture;
  logic        consume;
  logic        takeBranch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      S_IDLE: stateNext = S_REQ;
      S_REQ: begin
        if (imem_ack) begin
          stateNext = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          stateNext = S_REQ;
        end
      end
      default: stateNext = S_IDLE;
    endcase
  end

  // Handshake outputs depend on state only, never on ack/ready.
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state)
      S_REQ:   imem_req    = 1'b1;
      S_HOLD:  instr_valid = 1'b1;
      default: ;
    endcase
  end

  assign capture    = imem_req & imem_ack;
  assign consume    = instr_valid & instr_ready;
  assign pcPlus4    = pcReg + 32'd4;
  assign brOffset   = {{14{instrReg[15]}}, instrReg[15:0], 2'b00};
  assign takeBranch = branch & zero & ~jump;

  // Jump outranks a simultaneous taken branch.
  always_comb begin
    nextPc = pcPlus4;
    unique case (1'b1)
      jump:       nextPc = {pcPlus4[31:28], instrReg[25:0], 2'b00};
      takeBranch: nextPc = pcPlus4 + brOffset;
      default:    nextPc = pcPlus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcReg      <= RESET_PC;
      instrReg   <= 32'h0;
      retiredCnt <= 32'h0;
    end else begin
      if (capture) begin
        instrReg <= imem_rdata;
      end
      if (consume) begin
        pcReg      <= nextPc;
        retiredCnt <= retiredCnt + 32'd1;
      end
    end
  end

  assign imem_addr = pcReg;
  assign pc        = pcReg;
  assign pc_plus4  = pcPlus4;
  assign instr     = instrReg;
  assign retired   = retiredCnt;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: fetch and consume events are
// checked by a monitor against queued expectations.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch;
  logic        jump;
  logic        zero;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] retired;

  logic        rst1;
  logic        req1;
  logic [31:0] addr1;
  logic        ack1;
  logic [31:0] rdata1;
  logic [31:0] instr1;
  logic        valid1;
  logic        ready1;
  logic        br1;
  logic        jp1;
  logic        z1;
  logic [31:0] pc1;
  logic [31:0] pcp41;
  logic [31:0] ret1;

  int checks = 0;
  int errors = 0;

  logic [31:0] fetchQ[$];
  logic [63:0] consumeQ[$];

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .branch(branch), .jump(jump), .zero(zero),
    .pc(pc), .pc_plus4(pc_plus4), .retired(retired)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .clk(clk), .rst(rst1),
    .imem_req(req1), .imem_addr(addr1),
    .imem_ack(ack1), .imem_rdata(rdata1),
    .instr(instr1), .instr_valid(valid1),
    .instr_ready(ready1),
    .branch(br1), .jump(jp1), .zero(z1),
    .pc(pc1), .pc_plus4(pcp41), .retired(ret1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memRead(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'h0810_0004;
      32'h0040_0010: return 32'h0810_0000;
      32'h0040_0000: return 32'h0800_0040;
      32'h0000_0100: return 32'h1000_FFFE;
      32'h0000_0108: return 32'h0800_0008;
      default:       return {8'hA5, a[23:0]};
    endcase
  endfunction

  assign imem_rdata = memRead(imem_addr);

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expectFetch(input logic [31:0] a);
    fetchQ.push_back(a);
    consumeQ.push_back({a, memRead(a)});
  endtask

  task automatic consume(input logic br, input logic jp,
                         input logic z, input logic ackNext,
                         output int waited);
    waited = 0;
    while (!instr_valid && waited < 20) begin
      tick();
      waited++;
    end
    if (!instr_valid) begin
      check("consume_timeout", {31'h0, instr_valid}, 32'h1);
    end else begin
      branch      = br;
      jump        = jp;
      zero        = z;
      instr_ready = 1'b1;
      imem_ack    = ackNext;
      tick();
      instr_ready = 1'b0;
      branch      = 1'b0;
      jump        = 1'b0;
      zero        = 1'b0;
    end
  endtask

  // Monitor: compare every accepted fetch and every consume.
  always @(negedge clk) begin
    if (!rst && imem_req && imem_ack) begin
      if (fetchQ.size() == 0) begin
        check("unexpected_fetch", imem_addr, 32'hFFFF_FFFF);
      end else begin
        check("fetch_addr", imem_addr, fetchQ.pop_front());
      end
    end
    if (!rst && instr_valid && instr_ready) begin
      if (consumeQ.size() == 0) begin
        check("unexpected_consume", pc, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = consumeQ.pop_front();
        check("consume_pc", pc, e[63:32]);
        check("consume_instr", instr, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0;
    branch = 1'b0; jump = 1'b0; zero = 1'b0;
    rst1 = 1'b1; ack1 = 1'b1; rdata1 = 32'hA5A5_A5A5;
    ready1 = 1'b0; br1 = 1'b0; jp1 = 1'b0; z1 = 1'b0;
    tick();
    tick();

    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_pcp4", pc_plus4, 32'h4);
    check("rst_instr", instr, 32'h0);
    check("rst_retired", retired, 32'h0);

    // Sequential fetch with zero-wait memory.
    rst = 1'b0;
    imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expectFetch(32'(i * 4));
      consume(1'b0, 1'b0, 1'b0, 1'b1, w);
      if (i > 0) check("alternate_wait", 32'(w), 32'd1);
    end
    check("seq_retired", retired, 32'd4);
    check("seq_next_addr", imem_addr, 32'h10);

    // Jump chain: 0x10 -> 0x400010 -> 0x400000 -> 0x100.
    expectFetch(32'h10);
    consume(1'b0, 1'b1, 1'b0, 1'b1, w);
    check("jump1_addr", imem_addr, 32'h0040_0010);
    expectFetch(32'h0040_0010);
    consume(1'b0, 1'b1, 1'b0, 1'b1, w);
    check("jump2_addr", imem_addr, 32'h0040_0000);
    check("jump2_req", {31'h0, imem_req}, 32'h1);
    check("jump2_valid", {31'h0, instr_valid}, 32'h0);
    expectFetch(32'h0040_0000);
    consume(1'b1, 1'b1, 1'b1, 1'b1, w);
    check("jump_wins", imem_addr, 32'h100);

    // Branch taken backwards, then not taken.
    expectFetch(32'h100);
    consume(1'b1, 1'b0, 1'b1, 1'b1, w);
    check("br_taken", imem_addr, 32'h0FC);
    expectFetch(32'h0FC);
    consume(1'b0, 1'b0, 1'b1, 1'b1, w);
    check("after_fc", imem_addr, 32'h100);
    expectFetch(32'h100);
    consume(1'b1, 1'b0, 1'b0, 1'b0, w);
    check("br_not_taken", imem_addr, 32'h104);
    check("br_retired", retired, 32'd10);

    // Wait states and backpressure.
    expectFetch(32'h104);
    for (int i = 0; i < 3; i++) begin
      check("wait_req", {31'h0, imem_req}, 32'h1);
      check("wait_addr", imem_addr, 32'h104);
      tick();
    end
    imem_ack = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'h0, instr_valid}, 32'h1);
      check("bp_instr", instr, 32'hA500_0104);
      check("bp_pc", pc, 32'h104);
      check("bp_retired", retired, 32'd10);
      tick();
    end
    consume(1'b0, 1'b0, 1'b0, 1'b1, w);
    check("bp_retired_after", retired, 32'd11);

    // Jump to 0x20, then reset with an ack in the reset cycle.
    expectFetch(32'h108);
    consume(1'b0, 1'b1, 1'b0, 1'b1, w);
    check("mid_addr", imem_addr, 32'h20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_pc", pc, 32'h0);
    check("mrst_valid", {31'h0, instr_valid}, 32'h0);
    check("mrst_req", {31'h0, imem_req}, 32'h0);
    check("mrst_instr", instr, 32'h0);
    check("mrst_retired", retired, 32'h0);
    tick();
    expectFetch(32'h0);
    check("restart_req", {31'h0, imem_req}, 32'h1);
    check("restart_addr", imem_addr, 32'h0);
    consume(1'b0, 1'b0, 1'b0, 1'b0, w);
    check("restart_retired", retired, 32'd1);
    check("restart_next", imem_addr, 32'h4);

    // PC wrap on the second instance.
    check("wrap_rst_addr", addr1, 32'hFFFF_FFFC);
    check("wrap_rst_pcp4", pcp41, 32'h0);
    rst1 = 1'b0;
    tick();
    tick();
    check("wrap_valid", {31'h0, valid1}, 32'h1);
    check("wrap_instr", instr1, 32'hA5A5_A5A5);
    ready1 = 1'b1;
    tick();
    ready1 = 1'b0;
    check("wrap_addr", addr1, 32'h0);
    check("wrap_pcp4", pcp41, 32'h4);
    check("wrap_retired", ret1, 32'd1);

    tick();
    check("fetchq_empty", 32'(fetchQ.size()), 32'd0);
    check("consumeq_empty", 32'(consumeQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
